imm_extend_stage: RTL
=====================

# imm_extend_stage

Registered, parametrised immediate-generation stage for the RV32I/RV64I datapath, replacing the purely combinational extender. Takes a fetched instruction word plus the control unit's immediate-source code, builds the XLEN-wide immediate for every RISC-V format, and delivers it through a valid/ready handshake with a 2-entry skid buffer. It sits between decode and the execute-stage operand muxes. Pipeline stalls and flushes therefore apply to the immediate without combinational paths back to the control unit.

## Interface
- XLEN, default 32, output width; legal values 32 or 64 only.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  in_instr/in_immsrc valid.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  full instruction word.
- in_immsrc  in  3  immediate format code (see Operation).
- out_valid  out  1  out_imm/out_bad valid.
- out_ready  in  1  consumer accepts this cycle.
- out_imm  out  XLEN  extended immediate.
- out_bad  out  1  entry was issued with a reserved/none code (000).

## Operation
- Format codes and output; "sx" means sign-extend from instr[31] to XLEN:
  - 000 none: 0, out_bad=1.
  - 001 I: sx(instr[31:20]).
  - 010 U: sx({instr[31:12],12'b0}).
  - 011 S: sx({instr[31:25],instr[11:7]}).
  - 100 B: sx({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - 101 J: sx({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - 110 Z, CSR zimm: zero-extend instr[19:15].
  - 111 SH, shamt: zero-extend instr[25:20] if XLEN=64, else instr[24:20].
- Immediate is computed combinationally at input and stored, not the raw instruction.
- Occupancy FSM:
  - States EMPTY, ONE, TWO.
  - in_ready = (state != TWO).
  - out_valid = (state != EMPTY).
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Transitions, flush low:
  - EMPTY: push -> ONE.
  - ONE: push only -> TWO; pop only -> EMPTY; push+pop -> ONE, with the new entry becoming head.
  - TWO: pop -> ONE, with the second entry promoted to head; no push possible.
- Strict FIFO order. No entry is dropped or duplicated under any in_ready/out_ready pattern.
- flush=1: next state is EMPTY regardless of push/pop. A concurrent push is discarded. The pop handshake in that cycle still counts for the consumer.

## Timing
- Latency: an entry pushed at edge N is visible on out_* after edge N, i.e. 1 cycle.
- Throughput: 1 entry/cycle while out_ready=1.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from out_ready to in_ready.
- out_imm/out_bad are driven from the head register, with no logic after the flop.
- Reset, asserted at any time, including mid-transfer:
  - state=EMPTY, so out_valid=0 and in_ready=1.
  - out_imm=0, out_bad=0, and both entry registers cleared.
  - These take effect immediately, without waiting for a clock edge.
- First push is accepted on the first rising edge after rst deasserts.
- out_imm holds its value while out_valid=1 and out_ready=0. Changing it under stall is a bug.

## Structure
- Package imm_pkg:
  - immsrc_t enum with the 3-bit codes above.
  - occ_state_t enum (EMPTY/ONE/TWO).
  - Shared with the control unit, which must drive immsrc_t.
- Sub-module imm_format, combinational: (instr, immsrc, XLEN) -> (imm, bad). It is unit-testable standalone.
- Top level holds the FSM and two entry registers (head, tail), each XLEN+1 bits wide.
- Elaboration-time assertion that XLEN is 32 or 64.

## Test plan
- XLEN=32:
  - I with 0xFFF00093 -> out_imm 0xFFFFFFFF, out_bad=0, one cycle after accept.
  - B with 0xFE000EE3 -> 0xFFFFFFFC.
  - Z with 0x340FD073 -> 0x0000001F.
- XLEN=64:
  - U with 0x800000B7 -> 0xFFFFFFFF80000000.
  - SH with 0x03F09093 -> 0x3F.
- Backpressure:
  - Setup: out_ready=0, push I/S/J back-to-back.
  - While stalled: in_ready=0 after the 2nd accept; the 3rd is held at the input; out_imm stable.
  - Release out_ready=1: outputs appear in order, one per cycle, and in_ready returns to 1 the cycle after the first pop.
- Flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1. The flushed and concurrent entries never appear.
- Assert rst asynchronously between edges while in ONE -> out_valid=0, out_imm=0 immediately. After deassert, a push of code 000 yields out_imm=0, out_bad=1.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared immediate-format codes and skid-buffer occupancy states.
package imm_pkg;

  // Immediate-source code driven by the control unit.
  typedef enum logic [2:0] {
    IMM_NONE = 3'b000,
    IMM_I    = 3'b001,
    IMM_U    = 3'b010,
    IMM_S    = 3'b011,
    IMM_B    = 3'b100,
    IMM_J    = 3'b101,
    IMM_Z    = 3'b110,
    IMM_SH   = 3'b111
  } immsrc_t;

  // Number of entries held in the 2-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/imm_format.sv
// Combinational RISC-V immediate builder for every instruction format.
module imm_format
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  immsrc_t         immsrc,
  output logic [XLEN-1:0] imm,
  output logic            bad
);

  logic signed [11:0] i_field;
  logic signed [31:0] u_field;
  logic signed [11:0] s_field;
  logic signed [12:0] b_field;
  logic signed [20:0] j_field;

  assign i_field = instr[31:20];
  assign u_field = {instr[31:12], 12'b0};
  assign s_field = {instr[31:25], instr[11:7]};
  assign b_field = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign j_field = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Select and extend the field named by the immediate-source code.
  always_comb begin
    imm = '0;
    bad = 1'b0;
    case (immsrc)
      IMM_NONE: bad = 1'b1;
      IMM_I:    imm = XLEN'(i_field);
      IMM_U:    imm = XLEN'(u_field);
      IMM_S:    imm = XLEN'(s_field);
      IMM_B:    imm = XLEN'(b_field);
      IMM_J:    imm = XLEN'(j_field);
      IMM_Z:    imm = XLEN'(instr[19:15]);
      IMM_SH:   imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      default:  bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate stage: builds the immediate at the input and hands it
// downstream through a 2-entry skid buffer with valid/ready on both sides.
module imm_extend_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  immsrc_t         in_immsrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic            out_bad
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
      $error("imm_extend_stage: XLEN must be 32 or 64");
    end
  endgenerate

  // Entry layout: {bad, imm}
  localparam int EW = XLEN + 1;

  occ_state_t      state;
  logic [EW-1:0]   head;
  logic [EW-1:0]   tail;
  logic [XLEN-1:0] fmt_imm;
  logic            fmt_bad;
  logic [EW-1:0]   entry_new;
  logic            push;
  logic            pop;

  imm_format #(.XLEN(XLEN)) u_format (
    .instr  (in_instr),
    .immsrc (in_immsrc),
    .imm    (fmt_imm),
    .bad    (fmt_bad)
  );

  assign entry_new = {fmt_bad, fmt_imm};

  // Handshake flags come from registered state only, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Outputs are taken straight from the head register.
  assign out_imm = head[XLEN-1:0];
  assign out_bad = head[XLEN];

  // ---- input -> head/tail register boundary ----
  // Occupancy FSM and entry movement; flush empties the buffer and drops any
  // concurrent push, while an accompanying pop has still been seen downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= entry_new;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= entry_new;
          end else if (push) begin
            tail  <= entry_new;
            state <= TWO;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
